// File: rtl/regfile_pkg.sv
// Shared types and constants for the multi-port integer register file.
// Optional feature macro: REGFILE_BYPASS_EN (same-cycle write-to-read forwarding).
package regfile_pkg;

  // Walker state: INIT loads architectural reset values, RUN serves the pipeline.
  typedef enum logic [0:0] {
    StInit = 1'b0,
    StRun  = 1'b1
  } state_e;

  // x0 is hardwired to zero and never tracked by the scoreboard.
  localparam int unsigned ZeroReg = 0;

  // Registers with a non-zero architectural reset value.
  localparam int unsigned X5Reg   = 5;
  localparam int unsigned X9Reg   = 9;
  localparam logic [31:0] X5Reset = 32'd6;
  localparam logic [31:0] X9Reset = 32'h0000_2004;

  // Architectural reset value of register idx; callers resize to DATA_WIDTH.
  function automatic logic [31:0] init_val(input int unsigned idx);
    logic [31:0] val;
    val = '0;
    if (idx == X5Reg) begin
      val = X5Reset;
    end else if (idx == X9Reg) begin
      val = X9Reset;
    end
    return val;
  endfunction

endpackage

// File: rtl/regfile_init_seq.sv
// INIT/RUN sequencer for regfile_mp: walks every register once after reset,
// emitting one init write per cycle, then raises ready and stays in RUN.
module regfile_init_seq
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned REG_COUNT  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  ready,
  output logic                  init_we,
  output logic [ADDR_WIDTH-1:0] init_addr,
  output logic [DATA_WIDTH-1:0] init_data
);

  localparam logic [ADDR_WIDTH-1:0] LastIdx = ADDR_WIDTH'(REG_COUNT - 1);

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] idx_q;
  logic                  ready_q;

  // Walker FSM: one register per cycle, ready registered alongside the RUN transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StInit;
      idx_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        StInit: begin
          if (idx_q == LastIdx) begin
            state_q <= StRun;
            idx_q   <= '0;
            ready_q <= 1'b1;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        StRun: begin
          state_q <= StRun;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= StInit;
          idx_q   <= '0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  // A write presented while rst is high is discarded, so gate the init port too.
  assign init_we   = (state_q == StInit) && !rst;
  assign init_addr = idx_q;
  assign init_data = DATA_WIDTH'(init_val(32'(idx_q)));
  assign ready     = ready_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file: NUM_RD combinational read ports, two
// prioritised write ports (port 1 wins), per-register busy scoreboard and a
// sequential init walker that loads architectural reset values.
// Optional feature macro: REGFILE_BYPASS_EN forwards same-cycle writes and
// scoreboard updates to the read ports.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned REG_COUNT  = 32,
  parameter int unsigned NUM_RD     = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic                         ready,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] ra,
  output logic [NUM_RD*DATA_WIDTH-1:0] rd,
  output logic [NUM_RD-1:0]            rbusy,
  input  logic                         we0,
  input  logic                         we1,
  input  logic [ADDR_WIDTH-1:0]        wa0,
  input  logic [ADDR_WIDTH-1:0]        wa1,
  input  logic [DATA_WIDTH-1:0]        wd0,
  input  logic [DATA_WIDTH-1:0]        wd1,
  input  logic                         iss_valid,
  input  logic [ADDR_WIDTH-1:0]        iss_rd
);

  localparam logic [ADDR_WIDTH-1:0] ZeroAddr = ADDR_WIDTH'(ZeroReg);

  logic                  init_we;
  logic [ADDR_WIDTH-1:0] init_addr;
  logic [DATA_WIDTH-1:0] init_data;

  logic [DATA_WIDTH-1:0] regs_q [REG_COUNT];
  logic [REG_COUNT-1:0]  busy_q;
  logic [REG_COUNT-1:0]  busy_d;

  logic run_en;
  logic acc0;
  logic acc1;
  logic set_en;

  regfile_init_seq #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .REG_COUNT  (REG_COUNT)
  ) u_init_seq (
    .clk       (clk),
    .rst       (rst),
    .ready     (ready),
    .init_we   (init_we),
    .init_addr (init_addr),
    .init_data (init_data)
  );

  // Addresses at or above REG_COUNT have no storage behind them.
  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
    return 32'(addr) < REG_COUNT;
  endfunction

  // User ports and the issue strobe only act in RUN and never while rst is high.
  always_comb begin
    run_en = ready && !rst;
    acc0   = run_en && we0 && (wa0 != ZeroAddr) && in_range(wa0);
    acc1   = run_en && we1 && (wa1 != ZeroAddr) && in_range(wa1);
    set_en = run_en && iss_valid && (iss_rd != ZeroAddr) && in_range(iss_rd);
  end

  // Storage update: init walker first, then port 1 over port 0 on a shared address.
  always_ff @(posedge clk) begin
    for (int i = 0; i < REG_COUNT; i++) begin
      if (init_we && (init_addr == ADDR_WIDTH'(i))) begin
        regs_q[i] <= init_data;
      end else if (acc1 && (wa1 == ADDR_WIDTH'(i))) begin
        regs_q[i] <= wd1;
      end else if (acc0 && (wa0 == ADDR_WIDTH'(i))) begin
        regs_q[i] <= wd0;
      end
    end
  end

  // Scoreboard next state: a new issue supersedes a retiring write to the same register.
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < REG_COUNT; i++) begin
      if (set_en && (iss_rd == ADDR_WIDTH'(i))) begin
        busy_d[i] = 1'b1;
      end else if ((acc0 && (wa0 == ADDR_WIDTH'(i))) || (acc1 && (wa1 == ADDR_WIDTH'(i)))) begin
        busy_d[i] = 1'b0;
      end
    end
  end

  // Scoreboard register, cleared on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic                  busy;

    assign addr = ra[k*ADDR_WIDTH +: ADDR_WIDTH];

    // Read mux: zero in INIT/reset, for x0 and for unmapped addresses.
    always_comb begin
      data = '0;
      busy = 1'b0;
      if (run_en && (addr != ZeroAddr) && in_range(addr)) begin
        for (int i = 0; i < REG_COUNT; i++) begin
          if (addr == ADDR_WIDTH'(i)) begin
            data = regs_q[i];
            busy = busy_q[i];
          end
        end
`ifdef REGFILE_BYPASS_EN
        if (acc1 && (wa1 == addr)) begin
          data = wd1;
        end else if (acc0 && (wa0 == addr)) begin
          data = wd0;
        end
        if (set_en && (iss_rd == addr)) begin
          busy = 1'b1;
        end else if ((acc0 && (wa0 == addr)) || (acc1 && (wa1 == addr))) begin
          busy = 1'b0;
        end
`endif
      end
    end

    assign rd[k*DATA_WIDTH +: DATA_WIDTH] = data;
    assign rbusy[k]                       = busy;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios plus randomized
// traffic compared against an array-based reference model.
module tb_regfile_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int RC = 32;
  localparam int NR = 2;

  logic               clk;
  logic               rst;
  logic               ready;
  logic [NR*AW-1:0]   ra;
  logic [NR*DW-1:0]   rd;
  logic [NR-1:0]      rbusy;
  logic               we0, we1;
  logic [AW-1:0]      wa0, wa1;
  logic [DW-1:0]      wd0, wd1;
  logic               iss_valid;
  logic [AW-1:0]      iss_rd;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [DW-1:0] mreg [RC];
  bit            mbusy [RC];
  bit            mready;
  int            mwalk;

  regfile_mp #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .REG_COUNT  (RC),
    .NUM_RD     (NR)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ready     (ready),
    .ra        (ra),
    .rd        (rd),
    .rbusy     (rbusy),
    .we0       (we0),
    .we1       (we1),
    .wa0       (wa0),
    .wa1       (wa1),
    .wd0       (wd0),
    .wd1       (wd1),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] reset_value(int r);
    if (r == 5) return 32'd6;
    if (r == 9) return 32'h2004;
    return '0;
  endfunction

  function automatic logic [DW-1:0] exp_rd(int a);
    if (!mready || rst || a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (we1 && int'(wa1) == a) return wd1;
    if (we0 && int'(wa0) == a) return wd0;
`endif
    return mreg[a];
  endfunction

  function automatic bit exp_busy(int a);
    if (!mready || rst || a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (iss_valid && int'(iss_rd) == a) return 1'b1;
    if ((we0 && int'(wa0) == a) || (we1 && int'(wa1) == a)) return 1'b0;
`endif
    return mbusy[a];
  endfunction

  // Apply the rules for one clock edge using the inputs currently driven.
  task automatic model_edge();
    if (rst) begin
      mready = 1'b0;
      mwalk  = 0;
      foreach (mbusy[i]) mbusy[i] = 1'b0;
    end else if (!mready) begin
      mreg[mwalk] = reset_value(mwalk);
      mwalk++;
      if (mwalk == RC) mready = 1'b1;
    end else begin
      if (we0 && wa0 != 0) mreg[wa0] = wd0;
      if (we1 && wa1 != 0) mreg[wa1] = wd1;
      if (we0 && wa0 != 0) mbusy[wa0] = 1'b0;
      if (we1 && wa1 != 0) mbusy[wa1] = 1'b0;
      if (iss_valid && iss_rd != 0) mbusy[iss_rd] = 1'b1;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_reads(input string tag);
    #1;
    for (int k = 0; k < NR; k++) begin
      chk({tag, "_rd"}, rd[k*DW +: DW], exp_rd(int'(ra[k*AW +: AW])));
      chk({tag, "_rbusy"}, {31'b0, rbusy[k]}, {31'b0, exp_busy(int'(ra[k*AW +: AW]))});
    end
  endtask

  task automatic idle();
    we0 = 0; we1 = 0; wa0 = 0; wa1 = 0; wd0 = 0; wd1 = 0;
    iss_valid = 0; iss_rd = 0;
  endtask

  task automatic set_ra(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    ra = {a1, a0};
  endtask

  task automatic randomize_inputs(input int amax);
    we0 = 1'($urandom_range(0, 1));
    we1 = 1'($urandom_range(0, 1));
    wa0 = AW'($urandom_range(0, amax));
    wa1 = AW'($urandom_range(0, amax));
    wd0 = $urandom;
    wd1 = $urandom;
    iss_valid = 1'($urandom_range(0, 1));
    iss_rd = AW'($urandom_range(0, amax));
    set_ra(AW'($urandom_range(0, amax)), AW'($urandom_range(0, amax)));
  endtask

  int cycles;

  initial begin
    foreach (mreg[i]) mreg[i] = '0;
    foreach (mbusy[i]) mbusy[i] = 1'b0;
    mready = 0;
    mwalk  = 0;
    idle();
    set_ra(5'd0, 5'd0);
    rst = 1;
    #1;
    tick();
    tick();
    chk("reset_ready", {31'b0, ready}, 32'd0);
    set_ra(5'd5, 5'd9);
    check_reads("reset");

    // Init walk with random traffic that must be ignored.
    rst = 0;
    cycles = 0;
    while (!ready && cycles < 100) begin
      randomize_inputs(31);
      check_reads("init");
      tick();
      cycles++;
      chk("init_ready", {31'b0, ready}, {31'b0, mready});
    end
    chk("ready_latency", cycles, 32);
    idle();

    set_ra(5'd5, 5'd9);
    #1;
    chk("x5_reset", rd[31:0], 32'd6);
    chk("x9_reset", rd[63:32], 32'h2004);
    check_reads("resetvals");
    set_ra(5'd0, 5'd0);
    check_reads("x0");

    // Both ports hit x3; port 1 wins.
    we0 = 1; we1 = 1; wa0 = 3; wa1 = 3; wd0 = 32'hAAAA; wd1 = 32'h5555;
    tick();
    idle();
    set_ra(5'd3, 5'd3);
    #1;
    chk("x3_priority", rd[31:0], 32'h5555);
    check_reads("x3");

    // Scoreboard: issue, retire, and issue+retire in the same cycle.
    set_ra(5'd7, 5'd0);
    iss_valid = 1; iss_rd = 7;
    tick();
    idle();
    #1;
    chk("x7_busy_set", {31'b0, rbusy[0]}, 32'd1);
    we1 = 1; wa1 = 7; wd1 = 32'h77;
    tick();
    idle();
    #1;
    chk("x7_busy_clr", {31'b0, rbusy[0]}, 32'd0);
    we0 = 1; wa0 = 7; wd0 = 32'h78; iss_valid = 1; iss_rd = 7;
    check_reads("x7_setclr_pre");
    tick();
    idle();
    #1;
    chk("x7_set_wins", {31'b0, rbusy[0]}, 32'd1);

    // x0 ignores writes and issues.
    set_ra(5'd0, 5'd7);
    we0 = 1; wa0 = 0; wd0 = 32'h1234; iss_valid = 1; iss_rd = 0;
    check_reads("x0_pre");
    tick();
    idle();
    #1;
    chk("x0_data", rd[31:0], 32'd0);
    chk("x0_busy", {31'b0, rbusy[0]}, 32'd0);

    // Same-cycle read of a written register.
    set_ra(5'd4, 5'd4);
    we0 = 1; wa0 = 4; wd0 = 32'hBEEF;
    check_reads("x4_same");
    tick();
    idle();
    #1;
    chk("x4_next", rd[31:0], 32'hBEEF);

    // Randomized traffic, biased to few registers for collisions.
    for (int n = 0; n < 300; n++) begin
      randomize_inputs((n < 150) ? 7 : 31);
      check_reads("rand");
      tick();
    end
    idle();
    set_ra(5'd1, 5'd2);
    check_reads("rand_end");

    // Reset mid-RUN.
    we0 = 1; wa0 = 5; wd0 = 32'd99; iss_valid = 1; iss_rd = 12;
    tick();
    idle();
    set_ra(5'd5, 5'd12);
    #1;
    chk("x5_written", rd[31:0], 32'd99);
    chk("x12_busy", {31'b0, rbusy[1]}, 32'd1);
    rst = 1;
    we1 = 1; wa1 = 6; wd1 = 32'hDEAD; iss_valid = 1; iss_rd = 13;
    tick();
    idle();
    chk("midrst_ready", {31'b0, ready}, 32'd0);
    check_reads("midrst");
    rst = 0;
    cycles = 0;
    while (!ready && cycles < 100) begin
      randomize_inputs(31);
      tick();
      cycles++;
    end
    chk("ready_latency2", cycles, 32);
    idle();
    set_ra(5'd5, 5'd12);
    #1;
    chk("x5_restored", rd[31:0], 32'd6);
    chk("x12_busy_clr", {31'b0, rbusy[1]}, 32'd0);
    set_ra(5'd6, 5'd13);
    check_reads("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file for the RISC-V core, the successor to the single-write, two-read register bank. It provides NUM_RD combinational read ports and two write ports with defined priority. A per-register scoreboard (busy bits) lets a pipelined datapath detect pending writes. A sequential init walker loads the architectural reset values one register per cycle and holds `ready` low until it finishes.

## Interface
Parameters:
- DATA_WIDTH, 32: register width in bits.
- ADDR_WIDTH, 5: register address width.
- REG_COUNT, 32: number of registers; must be ≤ 2^ADDR_WIDTH.
- NUM_RD, 2: number of read ports.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- ready  out  1  high once the init walk is complete.
- ra  in  NUM_RD*ADDR_WIDTH  read addresses; port k is at slice k.
- rd  out  NUM_RD*DATA_WIDTH  read data, combinational from `ra`.
- rbusy  out  NUM_RD  scoreboard busy bit of each read address.
- we0, we1  in  1 each  write enables.
- wa0, wa1  in  ADDR_WIDTH each  write addresses.
- wd0, wd1  in  DATA_WIDTH each  write data.
- iss_valid  in  1  issue strobe; marks `iss_rd` as pending.
- iss_rd  in  ADDR_WIDTH  destination register being issued.

## Operation
- **Reset.** `rst` high at an edge forces state INIT, `idx`=0, `ready`=0 and all busy bits to 0. Register contents are not cleared by `rst` itself.
- **INIT state.**
  - Each cycle the walker writes `INIT_VAL(idx)` into reg[idx], then increments `idx`.
  - After writing reg[REG_COUNT-1] it goes to RUN and `ready`=1 at the next edge.
  - `INIT_VAL` is 6 for x5, 32'h2004 for x9, and 0 for every other register.
  - While in INIT, `we0`/`we1`/`iss_valid` are ignored and `rd` is forced to 0. `rbusy` is 0.
- **RUN state.**
  - Write port 0 writes when `we0` is high and `wa0`≠0; port 1 likewise.
  - If both ports target the same address in one cycle, port 1 wins.
  - Register 0 always reads 0 and is never busy.
- **Scoreboard.**
  - `iss_valid` with `iss_rd`≠0 sets busy[iss_rd].
  - Any accepted write to address a clears busy[a].
  - If a set and a clear hit the same address in the same cycle, set wins: the new producer supersedes the retiring one.
- **Out-of-range addresses.** Any address ≥ REG_COUNT reads 0, reads not busy, and writes to it are dropped.
- **Reset mid-operation.** `rst` during INIT or RUN restarts the walk from `idx`=0. In-flight writes in that cycle are discarded.

## Timing
- Read latency is 0 cycles: combinational from `ra`.
- Writes and scoreboard updates are visible from the edge after they are presented.
- `ready` rises exactly REG_COUNT cycles after the first cycle with `rst` low; for the default, 32 cycles.
- Output values in INIT and on reset: `ready`=0, `rd`=0, `rbusy`=0.

## Configuration
- `REGFILE_BYPASS_EN` defined:
  - A read whose address matches an accepted write in the same cycle returns that write's data, with port 1 taking priority.
  - `rbusy` also reflects the same-cycle clear and set.
- Not defined: reads return the stored value and the registered busy bit only; the new data appears the following cycle.

## Structure
- **Package `regfile_pkg`:**
  - state enum (INIT, RUN);
  - the `INIT_VAL` function or constant table, holding the x5 and x9 reset constants;
  - localparams for the zero-register address.
- **Sub-module `regfile_init_seq`:** INIT/RUN state machine, `idx` counter and `ready`. It outputs an init write enable, address and data, which the top muxes ahead of the user write ports.

## Test plan
- Deassert `rst`, then read x5, x9 and x0 once `ready` rises → `ready` rises after exactly 32 cycles; reads return 6, 32'h2004, 0.
- In RUN, drive `we0`=`we1`=1 with `wa0`=`wa1`=3, `wd0`=0xAAAA, `wd1`=0x5555 → reg3 reads 0x5555 the next cycle.
- Issue with `iss_rd`=7 → `rbusy` for x7 is 1 the next cycle. Write x7 later → busy clears. Issue x7 and write x7 in the same cycle → busy stays 1.
- Write 0x1234 to x0 and issue x0 → x0 still reads 0 and is never busy.
- With `REGFILE_BYPASS_EN`, write x4=0xBEEF while reading x4 → `rd` shows 0xBEEF in the same cycle. Without the macro → old value, then 0xBEEF the next cycle.
- Assert `rst` mid-RUN after writing x5=99 → `ready` drops, busy bits clear, and after 32 cycles x5 reads 6.
